// File: rtl/complex_sweep_ctrl.sv
// Sweep sequencer for the combinational complex evaluator: steps (x, y) downward
// one point per clock, samples the evaluator result and keeps hit statistics.
module complex_sweep_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] x_start,
    input  logic [W-1:0] y_start,
    input  logic [7:0]   count,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    input  logic         cmp_in,
    output logic         busy,
    output logic         done,
    output logic [7:0]   hit_cnt,
    output logic         found,
    output logic [W-1:0] first_x,
    output logic [W-1:0] first_y
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    // Operand step: modulo 2^W, so zero wraps to all-ones.
    function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
        return v - ONE_W;
    endfunction

    logic [1:0]   state_q,   state_d;
    logic [W-1:0] x_q,       x_d;
    logic [W-1:0] y_q,       y_d;
    logic [7:0]   rem_q,     rem_d;
    logic [7:0]   hit_q,     hit_d;
    logic         found_q,   found_d;
    logic [W-1:0] first_x_q, first_x_d;
    logic [W-1:0] first_y_q, first_y_d;
    logic         busy_q,    busy_d;
    logic         done_q,    done_d;

    // Next-state and datapath: load on start, sample-then-step while running.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        rem_d     = rem_q;
        hit_d     = hit_q;
        found_d   = found_q;
        first_x_d = first_x_q;
        first_y_d = first_y_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d       = x_start;
                    y_d       = y_start;
                    rem_d     = count;
                    hit_d     = 8'd0;
                    found_d   = 1'b0;
                    first_x_d = ZERO_W;
                    first_y_d = ZERO_W;
                    if (count != 8'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmp_in) begin
                    hit_d = hit_q + 8'd1;
                    if (!found_q) begin
                        found_d   = 1'b1;
                        first_x_d = x_q;
                        first_y_d = y_q;
                    end else begin
                        found_d = found_q;
                    end
                end else begin
                    hit_d = hit_q;
                end
                x_d   = step_down(x_q);
                y_d   = step_down(y_q);
                rem_d = rem_q - 8'd1;
                // Abort takes priority even on the final point: no done pulse.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (rem_q == 8'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            x_q       <= ZERO_W;
            y_q       <= ZERO_W;
            rem_q     <= 8'd0;
            hit_q     <= 8'd0;
            found_q   <= 1'b0;
            first_x_q <= ZERO_W;
            first_y_q <= ZERO_W;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rem_q     <= rem_d;
            hit_q     <= hit_d;
            found_q   <= found_d;
            first_x_q <= first_x_d;
            first_y_q <= first_y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign hit_cnt = hit_q;
    assign found   = found_q;
    assign first_x = first_x_q;
    assign first_y = first_y_q;

endmodule

// File: tb/tb_complex_sweep_ctrl.sv
// Randomized self-checking bench for complex_sweep_ctrl; cmp_in comes from a
// behavioural evaluator and results are predicted by enumerating sweep points.
module tb_complex_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] x_start;
    logic [7:0] y_start;
    logic [7:0] count;
    logic [7:0] x_o;
    logic [7:0] y_o;
    logic       cmp_in;
    logic       busy;
    logic       done;
    logic [7:0] hit_cnt;
    logic       found;
    logic [7:0] first_x;
    logic [7:0] first_y;

    int n_chk = 0;
    int n_err = 0;
    int cmp_mode = 0;
    int exp_hits, exp_fx, exp_fy;
    bit exp_found;

    complex_sweep_ctrl #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_start(x_start), .y_start(y_start), .count(count),
        .x_o(x_o), .y_o(y_o), .cmp_in(cmp_in),
        .busy(busy), .done(done), .hit_cnt(hit_cnt), .found(found),
        .first_x(first_x), .first_y(first_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the complex evaluator: 0 = x>y, 1 = never, 2 = scattered pattern.
    function automatic bit eval_pt(input int x, input int y, input int mode);
        if (mode == 0) return x > y;
        if (mode == 1) return 1'b0;
        return ((x ^ (y * 2)) % 3) == 0;
    endfunction

    assign cmp_in = eval_pt(int'(x_o), int'(y_o), cmp_mode);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, 32'(x_o), 32'd0);
        chk({tag, "_y"}, 32'(y_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_hits"}, 32'(hit_cnt), 32'd0);
        chk({tag, "_found"}, 32'(found), 32'd0);
        chk({tag, "_fx"}, 32'(first_x), 32'd0);
        chk({tag, "_fy"}, 32'(first_y), 32'd0);
    endtask

    // Reference: enumerate the first n points of the sweep and tally hits.
    task automatic predict(input int xs, input int ys, input int n, input int mode);
        exp_hits = 0; exp_found = 0; exp_fx = 0; exp_fy = 0;
        for (int i = 0; i < n; i++) begin
            int px, py;
            px = (xs - i + 256) % 256;
            py = (ys - i + 256) % 256;
            if (eval_pt(px, py, mode)) begin
                exp_hits++;
                if (!exp_found) begin
                    exp_found = 1; exp_fx = px; exp_fy = py;
                end
            end
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_hits"}, 32'(hit_cnt), 32'(exp_hits));
        chk({tag, "_found"}, 32'(found), 32'(exp_found));
        chk({tag, "_fx"}, 32'(first_x), 32'(exp_fx));
        chk({tag, "_fy"}, 32'(first_y), 32'(exp_fy));
    endtask

    // One sweep from IDLE; abort_at/restart_at are RUN cycle indices, -1 = none.
    task automatic run_sweep(input int xs, input int ys, input int cnt, input int mode,
                             input int abort_at, input int restart_at, input bit abort_with_start);
        int n_pts;
        bit aborted;
        cmp_mode = mode;
        x_start = 8'(xs); y_start = 8'(ys); count = 8'(cnt);
        start = 1'b1; abort = abort_with_start;
        tick();
        start = 1'b0; abort = 1'b0;
        aborted = 1'b0;
        n_pts = cnt;
        for (int k = 0; k < cnt; k++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_x", 32'(x_o), 32'((xs - k + 256) % 256));
            chk("run_y", 32'(y_o), 32'((ys - k + 256) % 256));
            start = (k == restart_at);
            x_start = 8'($urandom); y_start = 8'($urandom); count = 8'($urandom);
            abort = (k == abort_at);
            tick();
            start = 1'b0; abort = 1'b0;
            if (k == abort_at) begin
                aborted = 1'b1;
                n_pts = k + 1;
                break;
            end
        end
        predict(xs, ys, n_pts, mode);
        if (aborted) begin
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk_results("abort");
            tick();
            chk("abort_idle_done", 32'(done), 32'd0);
            chk_results("abort_hold");
        end else begin
            chk("end_done", 32'(done), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_x", 32'(x_o), 32'((xs - cnt + 256) % 256));
            chk("end_y", 32'(y_o), 32'((ys - cnt + 256) % 256));
            chk_results("end");
            tick();
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk_results("idle_hold");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        x_start = 8'h5A; y_start = 8'hA5; count = 8'd7;
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk_zero("post_reset_idle");

        run_sweep(8'hAF, 8'hAE, 4, 0, -1, -1, 1'b0);
        chk("basic_hits", 32'(hit_cnt), 32'd4);
        run_sweep(8'h02, 8'h01, 4, 0, -1, -1, 1'b0);
        chk("wrap_hits", 32'(hit_cnt), 32'd3);
        run_sweep(8'h33, 8'h10, 0, 0, -1, -1, 1'b0);
        run_sweep(8'h90, 8'h10, 3, 1, -1, -1, 1'b0);
        run_sweep(8'h80, 8'h20, 10, 2, 5, 3, 1'b0);
        run_sweep(8'h40, 8'h41, 5, 0, -1, -1, 1'b1);

        // Reset asserted during the third RUN cycle.
        cmp_mode = 0;
        x_start = 8'h50; y_start = 8'h40; count = 8'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_zero("midrst");
        rst_n = 1'b1;
        tick();
        chk_zero("midrst_idle");
        run_sweep(8'h50, 8'h40, 10, 0, -1, -1, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int cnt, ab, rs, gap;
            cnt = (r == 7) ? 255 : int'($urandom_range(0, 40));
            ab  = (cnt > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
            rs  = (cnt > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
            run_sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), cnt,
                      int'($urandom_range(0, 2)), ab, rs, 1'(($urandom_range(0, 4) == 0)));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                abort = 1'($urandom); x_start = 8'($urandom);
                tick();
                abort = 1'b0;
                chk("gap_busy", 32'(busy), 32'd0);
                chk_results("gap_hold");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
